// File: rtl/rv32i_mc_controller.sv
// rv32i_mc_controller: multicycle RV32I control unit.
// A Moore FSM sequences fetch / decode / execute over the shared datapath; the
// only Mealy term is PCWrite in BRANCH, which follows the ALU Zero flag.
// Also decodes op/funct3/funct7b5 into the 4-bit ALUControl code.
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   op, funct3, funct7b5  instruction register fields
//   Zero                  ALU result-is-zero flag (current cycle)
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl datapath mux/ALU controls
//   illegal               sticky illegal-opcode flag (MC_ILLEGAL_TRAP_EN only)
//
// Build option: define MC_ILLEGAL_TRAP_EN to trap unlisted opcodes in a TRAP
// state that raises `illegal` until reset. Without it, unlisted opcodes act as
// a 2-cycle NOP and neither the TRAP state nor the `illegal` port exist.

module rv32i_mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR1    = 4'd11;
    localparam logic [3:0] S_JALR2    = 4'd12;
    localparam logic [3:0] S_LUI      = 4'd13;
    localparam logic [3:0] S_AUIPC    = 4'd14;
`ifdef MC_ILLEGAL_TRAP_EN
    localparam logic [3:0] S_TRAP     = 4'd15;
`endif

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    logic [3:0] state;
    logic [3:0] next_state;
    logic       br_taken;

    // ALU op for register/immediate arithmetic; bit 30 only selects SUB for
    // register forms, since ADDI reuses that bit as immediate data.
    function automatic logic [3:0] funct_alu(input logic is_r, input logic [2:0] f3,
                                             input logic f7b5);
        case (f3)
            3'b000:  funct_alu = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  funct_alu = ALU_SLL;
            3'b010:  funct_alu = ALU_SLT;
            3'b011:  funct_alu = ALU_SLTU;
            3'b100:  funct_alu = ALU_XOR;
            3'b101:  funct_alu = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  funct_alu = ALU_OR;
            default: funct_alu = ALU_AND;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXECR;
                    OP_I:              next_state = S_EXECI;
                    OP_BR:             next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR1;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_AUIPC;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:           next_state = S_TRAP;
`else
                    default:           next_state = S_FETCH;
`endif
                endcase
            end
            // op[5] separates stores (0100011) from loads (0000011)
            S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  next_state = S_MEMWB;
            S_EXECR,
            S_EXECI,
            S_JAL,
            S_JALR2,
            S_AUIPC:    next_state = S_ALUWB;
            S_JALR1:    next_state = S_JALR2;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:     next_state = S_TRAP;
`endif
            default:    next_state = S_FETCH;
        endcase
    end

    // Output decode; everything is held at 0 while reset is asserted
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 3'b000;
        ALUControl = ALU_ADD;
        br_taken   = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ImmSrc  = op[5] ? IMM_S : IMM_I;
                end
                S_MEMREAD: AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = funct_alu(1'b1, funct3, funct7b5);
                end
                S_EXECI: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b01;
                    ImmSrc     = IMM_I;
                    ALUControl = funct_alu(1'b0, funct3, funct7b5);
                end
                S_ALUWB: RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA = 2'b10;
                    case (funct3)
                        3'b000: begin ALUControl = ALU_SUB;  br_taken = Zero;  end
                        3'b001: begin ALUControl = ALU_SUB;  br_taken = !Zero; end
                        3'b100: begin ALUControl = ALU_SLT;  br_taken = !Zero; end
                        3'b101: begin ALUControl = ALU_SLT;  br_taken = Zero;  end
                        3'b110: begin ALUControl = ALU_SLTU; br_taken = !Zero; end
                        3'b111: begin ALUControl = ALU_SLTU; br_taken = Zero;  end
                        default: br_taken = 1'b0;
                    endcase
                    PCWrite = br_taken;
                end
                S_JAL, S_JALR2: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
                S_JALR1: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ImmSrc  = IMM_I;
                end
                S_LUI: begin
                    ImmSrc    = IMM_U;
                    ResultSrc = 2'b11;
                    RegWrite  = 1'b1;
                end
                S_AUIPC: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = IMM_U;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    // Sticky by virtue of TRAP only being left through reset
    assign illegal = !reset && (state == S_TRAP);
`endif

endmodule

// File: tb/tb_rv32i_mc_controller.sv
// Testbench for rv32i_mc_controller: each instruction class is turned into the
// list of per-cycle control words the datapath should see, and the DUT outputs
// are compared against that list cycle by cycle. Honours MC_ILLEGAL_TRAP_EN.

module tb_rv32i_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rv32i_mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
`ifdef MC_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    // Control word: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl}
    logic [17:0] act;
    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                           JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111,
                           BAD = 7'b1111111;

    function automatic logic [17:0] cw(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] imm, input logic [3:0] alu);
        return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu};
    endfunction

    // Mnemonic tables: ALU code by funct3 and the branch ALU op / taken rule
    function automatic logic [3:0] alu_ref(input logic is_r, input logic [2:0] f3, input logic f7);
        int tab [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
        if (f3 == 3'd0 && is_r && f7) return 4'd1;
        if (f3 == 3'd5 && f7)         return 4'd9;
        return 4'(tab[f3]);
    endfunction

    function automatic logic [3:0] br_alu(input logic [2:0] f3);
        int tab [8] = '{1, 1, 0, 0, 5, 5, 6, 6};
        return 4'(tab[f3]);
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic z);
        // 0 = never, 1 = taken when Zero, 2 = taken when not Zero
        int rule [8] = '{1, 2, 0, 0, 2, 1, 2, 1};
        return (rule[f3] == 1) ? z : (rule[f3] == 2) ? !z : 1'b0;
    endfunction

    logic [17:0] exp_q[$];

    function automatic void build(input logic [6:0] o, input logic [2:0] f3,
                                  input logic f7, input logic z);
        logic [17:0] wb, jmp;
        wb  = cw(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'd0, 4'd0);
        jmp = cw(1,0,0,0,0, 2'b00, 2'b01, 2'b10, 3'd0, 4'd0);
        exp_q.delete();
        exp_q.push_back(cw(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'd0, 4'd0));
        exp_q.push_back(cw(0,0,0,0,0, 2'b00, 2'b01, 2'b01, (o == JL) ? 3'd3 : 3'd2, 4'd0));
        case (o)
            LW: begin
                exp_q.push_back(cw(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'd0, 4'd0));
                exp_q.push_back(cw(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'd0, 4'd0));
                exp_q.push_back(cw(0,0,0,0,1, 2'b01, 2'b00, 2'b00, 3'd0, 4'd0));
            end
            SW: begin
                exp_q.push_back(cw(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'd1, 4'd0));
                exp_q.push_back(cw(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 3'd0, 4'd0));
            end
            RT: begin
                exp_q.push_back(cw(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'd0, alu_ref(1, f3, f7)));
                exp_q.push_back(wb);
            end
            IT: begin
                exp_q.push_back(cw(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'd0, alu_ref(0, f3, f7)));
                exp_q.push_back(wb);
            end
            BR: exp_q.push_back(cw(br_taken(f3, z),0,0,0,0, 2'b00, 2'b10, 2'b00, 3'd0, br_alu(f3)));
            JL: begin
                exp_q.push_back(jmp);
                exp_q.push_back(wb);
            end
            JR: begin
                exp_q.push_back(cw(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'd0, 4'd0));
                exp_q.push_back(jmp);
                exp_q.push_back(wb);
            end
            LU: exp_q.push_back(cw(0,0,0,0,1, 2'b11, 2'b00, 2'b00, 3'd4, 4'd0));
            AU: begin
                exp_q.push_back(cw(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'd4, 4'd0));
                exp_q.push_back(wb);
            end
            default: ;
        endcase
    endfunction

    // Starts 1 time unit after the edge that enters FETCH; ends the same way.
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z);
        build(o, f3, f7, z);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            n_checks++;
            if (act !== exp_q[k]) begin
                n_fail++;
                $display("FAIL %s cycle %0d: control word %h, expected %h", name, k, act, exp_q[k]);
            end
`ifdef MC_ILLEGAL_TRAP_EN
            n_checks++;
            if (illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL %s cycle %0d illegal: got %b, expected 0", name, k, illegal);
            end
`endif
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (act !== exp_q[0]) begin
            n_fail++;
            $display("FAIL %s back_to_fetch after %0d cycles: control word %h, expected %h",
                     name, exp_q.size(), act, exp_q[0]);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (act !== 18'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: control word %h, expected 0", i, act);
            end
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (act !== cw(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'd0, 4'd0)) begin
            n_fail++;
            $display("FAIL reset_first_fetch: control word %h, expected %h", act,
                     cw(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'd0, 4'd0));
        end
    endtask

    task automatic test_alu;
        run_instr("sub",  RT, 3'b000, 1'b1, 1'b0);
        run_instr("add",  RT, 3'b000, 1'b0, 1'b0);
        run_instr("sra",  RT, 3'b101, 1'b1, 1'b0);
        run_instr("addi", IT, 3'b000, 1'b1, 1'b0);
        run_instr("srai", IT, 3'b101, 1'b1, 1'b0);
        run_instr("srli", IT, 3'b101, 1'b0, 1'b1);
    endtask

    task automatic test_branch;
        run_instr("bne_nz",  BR, 3'b001, 1'b0, 1'b0);
        run_instr("bne_z",   BR, 3'b001, 1'b0, 1'b1);
        run_instr("beq_z",   BR, 3'b000, 1'b0, 1'b1);
        run_instr("bltu_nz", BR, 3'b110, 1'b0, 1'b0);
        run_instr("bge_z",   BR, 3'b101, 1'b1, 1'b1);
        run_instr("br010_z", BR, 3'b010, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        run_instr("lw",    LW, 3'b010, 1'b0, 1'b1);
        run_instr("sw",    SW, 3'b010, 1'b0, 1'b0);
        run_instr("jalr",  JR, 3'b000, 1'b0, 1'b1);
        run_instr("jal",   JL, 3'b000, 1'b0, 1'b0);
        run_instr("lui",   LU, 3'b000, 1'b1, 1'b0);
        run_instr("auipc", AU, 3'b000, 1'b0, 1'b1);
    endtask

    task automatic test_reset_abort;
        op = LW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        @(posedge clk); #1;   // DECODE
        @(posedge clk); #1;   // MEMADR
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (act !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_abort: control word %h, expected 0", act);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (act !== cw(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 3'd0, 4'd0)) begin
            n_fail++;
            $display("FAIL reset_abort_fetch: control word %h, expected fetch", act);
        end
    endtask

    task automatic test_random;
        logic [6:0] ops [9] = '{LW, SW, RT, IT, BR, JL, JR, LU, AU};
        for (int i = 0; i < 60; i++) begin
            run_instr("random", ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_illegal;
`ifdef MC_ILLEGAL_TRAP_EN
        op = BAD; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
        @(posedge clk); #1;   // DECODE
        @(posedge clk); #1;   // TRAP
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (act !== 18'd0 || illegal !== 1'b1) begin
                n_fail++;
                $display("FAIL trap cycle %0d: control word %h illegal %b, expected 0 and 1",
                         i, act, illegal);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (illegal !== 1'b0 || act !== 18'd0) begin
            n_fail++;
            $display("FAIL trap_reset: illegal %b control word %h, expected 0 and 0", illegal, act);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        run_instr("after_trap", RT, 3'b111, 1'b0, 1'b0);
`else
        run_instr("illegal_nop", BAD, 3'b000, 1'b0, 1'b0);
        run_instr("after_nop",   RT,  3'b111, 1'b0, 1'b0);
`endif
    endtask

    initial begin
        test_reset;
        test_alu;
        test_branch;
        test_back_to_back;
        test_reset_abort;
        test_random;
        test_illegal;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rv32i_mc_controller.md
# rv32i_mc_controller

Multicycle control unit for the RV32I core. A Moore FSM, plus one Mealy branch-enable term, sequences the shared datapath (instruction/data memory port, register file, the single 4-bit-controlled ALU) through fetch, decode and execute steps. It decodes `op`/`funct3`/`funct7b5` into the `ALUControl` code consumed by `alu`. It sits between the instruction register and the datapath muxes, and is the only source of every datapath write enable.

## Interface
Parameters:
- none; the encodings below are fixed.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  7  `Instr[6:0]` from the instruction register.
- `funct3`  in  3  `Instr[14:12]`.
- `funct7b5`  in  1  `Instr[30]`.
- `Zero`  in  1  ALU `ALUResult == 0` flag, current cycle.
- `PCWrite`  out  1  PC register load enable.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  data memory write strobe.
- `IRWrite`  out  1  instruction register / OldPC load enable.
- `RegWrite`  out  1  register-file write enable.
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = RD1.
- `ALUSrcB`  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4.
- `ImmSrc`  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `ALUControl`  out  4  0 = ADD, 1 = SUB, 2 = AND, 3 = OR, 4 = XOR, 5 = SLT, 6 = SLTU, 7 = SLL, 8 = SRL, 9 = SRA.
- `illegal`  out  1  sticky illegal-opcode flag; present only with `MC_ILLEGAL_TRAP_EN`.

## Operation
State sequence by instruction class:
- FETCH: `IRWrite=1`, `PCWrite=1`, `AdrSrc=0`, `ALUSrcA=00`, `ALUSrcB=10`, ADD, `ResultSrc=10`. Next state: DECODE.
- DECODE: `ALUSrcA=01`, `ALUSrcB=01`, ADD. `ImmSrc=J` if `op=1101111`, else B. The branch/jump target is latched in ALUOut. Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR1
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other value → see Configuration.
- MEMADR: `ALUSrcA=10`, `ALUSrcB=01`, ADD, `ImmSrc` = I for loads, S for stores. Next state: MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: `AdrSrc=1`. Next state: MEMWB.
- MEMWB: `ResultSrc=01`, `RegWrite=1`. Next state: FETCH.
- MEMWRITE: `AdrSrc=1`, `MemWrite=1`. Next state: FETCH.
- EXECR: `ALUSrcA=10`, `ALUSrcB=00`, funct decode. Next state: ALUWB.
- EXECI: as EXECR but `ALUSrcB=01`, `ImmSrc=I`. Next state: ALUWB.
- ALUWB: `ResultSrc=00`, `RegWrite=1`. Next state: FETCH.
- BRANCH: `ALUSrcA=10`, `ALUSrcB=00`, `ResultSrc=00`. ALU op and taken condition by `funct3`:
  - 000 BEQ: SUB, taken = `Zero`
  - 001 BNE: SUB, taken = `!Zero`
  - 100 BLT: SLT, taken = `!Zero`
  - 101 BGE: SLT, taken = `Zero`
  - 110 BLTU: SLTU, taken = `!Zero`
  - 111 BGEU: SLTU, taken = `Zero`
  - 010 / 011: never taken.
  - `PCWrite` = taken (combinational on `Zero`). Next state: FETCH.
- JAL: `ALUSrcA=01`, `ALUSrcB=10`, ADD, `ResultSrc=00`, `PCWrite=1`. Next state: ALUWB, which writes OldPC+4.
- JALR1: `ALUSrcA=10`, `ALUSrcB=01`, `ImmSrc=I`, ADD. Next state: JALR2.
- JALR2: identical outputs to JAL. Next state: ALUWB. Clearing the target LSB is done by the datapath, not here.
- LUI: `ImmSrc=U`, `ResultSrc=11`, `RegWrite=1`. Next state: FETCH.
- AUIPC: `ALUSrcA=01`, `ALUSrcB=01`, `ImmSrc=U`, ADD. Next state: ALUWB.

Funct decode (EXECR / EXECI), by `funct3`:
- 000: SUB only if EXECR and `funct7b5=1`; otherwise ADD (ADDI ignores bit 30).
- 001: SLL
- 010: SLT
- 011: SLTU
- 100: XOR
- 101: SRA if `funct7b5=1`, else SRL
- 110: OR
- 111: AND

Default output rule: every output not listed for a state is 0.

## Timing
- `reset` high at a clock edge loads FETCH. While `reset` is high, all outputs are forced to 0, including `PCWrite`, `IRWrite`, `RegWrite` and `MemWrite`.
- Reset asserted mid-instruction aborts that instruction; no write enable is asserted in the reset cycle.
- All outputs except BRANCH `PCWrite` depend only on state and IR fields. They are valid within the state cycle and change only after a clock edge.
- Cycles per instruction:
  - lw: 5
  - sw: 4
  - R-type / I-type ALU: 4
  - branch: 3
  - jal: 4
  - jalr: 5
  - lui: 3
  - auipc: 4
- Write enables are never asserted in two consecutive cycles for the same instruction, except `RegWrite` and `PCWrite` in the final states as listed above.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - An unlisted `op` in DECODE moves the FSM to TRAP.
  - TRAP asserts `illegal=1` with all other outputs 0, and stays there until `reset`.
  - `illegal` resets to 0.
- Macro undefined:
  - An unlisted `op` in DECODE returns to FETCH (executes as a 2-cycle NOP).
  - Neither the `illegal` port nor the TRAP state exists.

## Test plan
- Reset held 2 cycles, then released: all outputs 0 during reset; the first cycle after shows FETCH with `IRWrite=1`, `PCWrite=1`, `ALUSrcB=10`, `ALUControl=0`.
- `op=0110011`, `funct3=000`, `funct7b5=1` (SUB): EXECR shows `ALUControl=1`; ALUWB shows `RegWrite=1`; back in FETCH 4 cycles after the start.
- `op=0010011`, `funct3=000`, `funct7b5=1` (ADDI): `ALUControl=0`. `funct3=101`, `funct7b5=1` (SRAI): `ALUControl=9`.
- BNE with `Zero=0`: `PCWrite=1` in BRANCH. With `Zero=1`: `PCWrite=0`. BLTU shows `ALUControl=6`.
- Sequence lw, sw, jalr: state traces MEMADR→MEMREAD→MEMWB, MEMADR→MEMWRITE, JALR1→JALR2→ALUWB. `MemWrite=1` appears only in MEMWRITE. Cycle counts are 5, 4 and 5.
- `op=1111111`: with the macro, TRAP is entered and `illegal=1` stays set until reset. Without it, FETCH follows DECODE and no write enable is asserted.
